debounce_botones: RTL and testbench

//   Two-channel push-button conditioner. Sits directly upstream of the process-start FSM.

---
 rtl/debounce_botones.sv | 118 +++++++++++
 tb/tb_debounce_botones.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/debounce_botones.sv
// Two-channel push-button conditioner: 2-FF synchroniser, debounce FSM per channel,
// one-cycle press pulse and debounced level outputs.
module debounce_botones #(
  parameter int unsigned CICLOS_ESTABLE = 50000,
  parameter int unsigned ANCHO_CONT     = 16,
  parameter bit          ACTIVO_ALTO    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in_1,
  input  logic btn_in_2,
  output logic boton_1,
  output logic boton_2,
  output logic nivel_1,
  output logic nivel_2
);

  typedef enum logic [1:0] {
    StSuelto     = 2'd0,
    StConfPulsa  = 2'd1,
    StPulsado    = 2'd2,
    StConfSuelta = 2'd3
  } estado_e;

  localparam logic [ANCHO_CONT-1:0] ContMax = ANCHO_CONT'(CICLOS_ESTABLE - 1);

  logic [1:0] btn_in;
  logic [1:0] pulso;
  logic [1:0] nivel;

  assign btn_in  = {btn_in_2, btn_in_1};
  assign boton_1 = pulso[0];
  assign boton_2 = pulso[1];
  assign nivel_1 = nivel[0];
  assign nivel_2 = nivel[1];

  for (genvar c = 0; c < 2; c++) begin : g_canal
    estado_e               estado_q, estado_d;
    logic [ANCHO_CONT-1:0] cont_q, cont_d;
    logic                  sinc1_q, sinc2_q;
    logic                  pulso_q, pulso_d;
    logic                  nivel_q, nivel_d;
    logic                  p;

    // Normalise polarity so that p = 1 always means pressed.
    assign p = btn_in[c] ^ ~ACTIVO_ALTO;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sinc1_q  <= 1'b0;
        sinc2_q  <= 1'b0;
        estado_q <= StSuelto;
        cont_q   <= '0;
        pulso_q  <= 1'b0;
        nivel_q  <= 1'b0;
      end else begin
        sinc1_q  <= p;
        sinc2_q  <= sinc1_q;
        estado_q <= estado_d;
        cont_q   <= cont_d;
        pulso_q  <= pulso_d;
        nivel_q  <= nivel_d;
      end
    end

    always_comb begin
      estado_d = estado_q;
      cont_d   = cont_q;
      pulso_d  = 1'b0;
      case (estado_q)
        StSuelto: begin
          if (sinc2_q) begin
            estado_d = StConfPulsa;
            cont_d   = '0;
          end
        end
        StConfPulsa: begin
          if (!sinc2_q) begin
            estado_d = StSuelto;
            cont_d   = '0;
          end else if (cont_q == ContMax) begin
            estado_d = StPulsado;
            cont_d   = '0;
            pulso_d  = 1'b1;
          end else begin
            cont_d = cont_q + ANCHO_CONT'(1);
          end
        end
        StPulsado: begin
          if (!sinc2_q) begin
            estado_d = StConfSuelta;
            cont_d   = '0;
          end
        end
        StConfSuelta: begin
          if (sinc2_q) begin
            estado_d = StPulsado;
            cont_d   = '0;
          end else if (cont_q == ContMax) begin
            estado_d = StSuelto;
            cont_d   = '0;
          end else begin
            cont_d = cont_q + ANCHO_CONT'(1);
          end
        end
        default: begin
          estado_d = StSuelto;
          cont_d   = '0;
        end
      endcase
      nivel_d = (estado_d == StPulsado) || (estado_d == StConfSuelta);
    end

    assign pulso[c] = pulso_q;
    assign nivel[c] = nivel_q;
  end

endmodule

// File: tb/tb_debounce_botones.sv
// Randomised bench for debounce_botones: active-high and active-low instances checked
// against a run-length model of the debounce rules.
module tb_debounce_botones;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic b1 = 1'b0, b2 = 1'b0;
  logic ah_boton_1, ah_boton_2, ah_nivel_1, ah_nivel_2;
  logic al_boton_1, al_boton_2, al_nivel_1, al_nivel_2;

  int n_chk = 0;
  int n_err = 0;

  // Model: two-stage delay of p, debounced level, run of disagreeing samples.
  logic s1[2], s2[2], deb[2], pul[2];
  int   run[2];
  int   hold_left[2];
  logic lvl[2];

  always #5 clk = ~clk;

  debounce_botones #(.CICLOS_ESTABLE(N), .ANCHO_CONT(3), .ACTIVO_ALTO(1'b1)) u_ah (
    .clk(clk), .reset(reset), .btn_in_1(b1), .btn_in_2(b2),
    .boton_1(ah_boton_1), .boton_2(ah_boton_2), .nivel_1(ah_nivel_1), .nivel_2(ah_nivel_2)
  );

  debounce_botones #(.CICLOS_ESTABLE(N), .ANCHO_CONT(3), .ACTIVO_ALTO(1'b0)) u_al (
    .clk(clk), .reset(reset), .btn_in_1(~b1), .btn_in_2(~b2),
    .boton_1(al_boton_1), .boton_2(al_boton_2), .nivel_1(al_nivel_1), .nivel_2(al_nivel_2)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      s1[c] = 1'b0; s2[c] = 1'b0; deb[c] = 1'b0; pul[c] = 1'b0; run[c] = 0;
    end
  endtask

  // A new level is accepted after N+1 consecutive synchronised samples disagree with it.
  task automatic model_edge(input logic p1, input logic p2);
    logic smp;
    logic p[2];
    p[0] = p1; p[1] = p2;
    for (int c = 0; c < 2; c++) begin
      smp    = s2[c];
      s2[c]  = s1[c];
      s1[c]  = p[c];
      pul[c] = 1'b0;
      if (smp != deb[c]) begin
        run[c]++;
        if (run[c] == N + 1) begin
          deb[c] = smp;
          pul[c] = smp;
          run[c] = 0;
        end
      end else begin
        run[c] = 0;
      end
    end
  endtask

  task automatic check_all();
    check_bit("ah_boton_1", ah_boton_1, pul[0]);
    check_bit("ah_boton_2", ah_boton_2, pul[1]);
    check_bit("ah_nivel_1", ah_nivel_1, deb[0]);
    check_bit("ah_nivel_2", ah_nivel_2, deb[1]);
    check_bit("al_boton_1", al_boton_1, pul[0]);
    check_bit("al_boton_2", al_boton_2, pul[1]);
    check_bit("al_nivel_1", al_nivel_1, deb[0]);
    check_bit("al_nivel_2", al_nivel_2, deb[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(b1, b2);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (5) begin
      @(posedge clk);
      model_reset();
      @(negedge clk);
      check_all();
    end
    reset = 1'b0;
    repeat (3) step();

    // Directed: press held from before edge 0 pulses exactly after edge N+2.
    b1 = 1'b1;
    for (int j = 0; j < 40; j++) begin
      step();
      check_bit("dir_pulse_1", ah_boton_1, (j == N + 2) ? 1'b1 : 1'b0);
      check_bit("dir_nivel_1", ah_nivel_1, (j >= N + 2) ? 1'b1 : 1'b0);
      check_bit("dir_boton_2", ah_boton_2, 1'b0);
    end
    b1 = 1'b0;
    for (int j = 0; j < 15; j++) begin
      step();
      check_bit("dir_release", ah_nivel_1, (j < N + 2) ? 1'b1 : 1'b0);
      check_bit("dir_no_pulse", ah_boton_1, 1'b0);
    end

    // Both buttons together pulse in the same cycle.
    b1 = 1'b1; b2 = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step();
      check_bit("dual_1", ah_boton_1, (j == N + 2) ? 1'b1 : 1'b0);
      check_bit("dual_2", ah_boton_2, (j == N + 2) ? 1'b1 : 1'b0);
    end
    b1 = 1'b0; b2 = 1'b0;
    repeat (12) step();

    hold_left[0] = 0; hold_left[1] = 0;
    lvl[0] = 1'b0; lvl[1] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold_left[c] == 0) begin
          lvl[c] = ($urandom_range(0, 1) == 1);
          hold_left[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3)
                                                     : $urandom_range(4, 14);
        end
        hold_left[c]--;
      end
      b1 = lvl[0];
      b2 = lvl[1];
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (2) begin
          @(posedge clk);
          model_reset();
        end
        @(negedge clk);
        check_all();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
